// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: round-robin sequencing controller for a shared
// 4-operand / 2-result combinational ALU datapath. Accepts one request at a
// time, holds the operands for a per-opcode settle time, captures both results
// and returns them on a valid/ready response channel tagged with the requester.
// Optional: define ALU_OP_SCHEDULER_STATS_EN to add per-requester saturating
// completion counters (o_done_cnt0 / o_done_cnt1).
module alu_op_scheduler #(
  parameter int          WIDTH       = 16,
  parameter int          SETTLE_FAST = 1,
  parameter int          SETTLE_SLOW = 3,
  parameter logic [15:0] SLOW_MASK   = 16'hFF0C
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [WIDTH-1:0] i_req0_d0,
  input  logic [WIDTH-1:0] i_req0_d1,
  input  logic [WIDTH-1:0] i_req0_d2,
  input  logic [WIDTH-1:0] i_req0_d3,
  input  logic [3:0]       i_req0_sel,
  input  logic [WIDTH-1:0] i_req1_d0,
  input  logic [WIDTH-1:0] i_req1_d1,
  input  logic [WIDTH-1:0] i_req1_d2,
  input  logic [WIDTH-1:0] i_req1_d3,
  input  logic [3:0]       i_req1_sel,
  output logic [WIDTH-1:0] o_alu_d0,
  output logic [WIDTH-1:0] o_alu_d1,
  output logic [WIDTH-1:0] o_alu_d2,
  output logic [WIDTH-1:0] o_alu_d3,
  output logic [3:0]       o_alu_sel,
  input  logic [WIDTH-1:0] i_alu_o0,
  input  logic [WIDTH-1:0] i_alu_o1,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [WIDTH-1:0] o_rsp_r0,
  output logic [WIDTH-1:0] o_rsp_r1,
  output logic             o_busy
`ifdef ALU_OP_SCHEDULER_STATS_EN
  ,
  output logic [15:0]      o_done_cnt0,
  output logic [15:0]      o_done_cnt1
`endif
);

  // A settle time of zero would never complete, so it is clamped to one.
  localparam int SF      = (SETTLE_FAST < 1) ? 1 : SETTLE_FAST;
  localparam int SS      = (SETTLE_SLOW < 1) ? 1 : SETTLE_SLOW;
  localparam int CNT_MAX = (SF > SS) ? SF : SS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] N_FAST = CW'(SF);
  localparam logic [CW-1:0] N_SLOW = CW'(SS);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_e;

  state_e           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_d0_q, alu_d0_d, alu_d1_q, alu_d1_d;
  logic [WIDTH-1:0] alu_d2_q, alu_d2_d, alu_d3_q, alu_d3_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_r0_q, rsp_r0_d, rsp_r1_q, rsp_r1_d;
  logic             gnt_id;
  logic [1:0]       req_ready;
  logic [3:0]       gnt_sel;

  // Next-state, arbitration and datapath-register loading.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    cnt_d       = cnt_q;
    alu_d0_d    = alu_d0_q;
    alu_d1_d    = alu_d1_q;
    alu_d2_d    = alu_d2_q;
    alu_d3_d    = alu_d3_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_r0_d    = rsp_r0_q;
    rsp_r1_d    = rsp_r1_q;
    req_ready   = 2'b00;
    // Both valid: the requester that did not win last time goes first.
    gnt_id      = (i_req_valid == 2'b11) ? ~rr_last_q : i_req_valid[1];
    gnt_sel     = gnt_id ? i_req1_sel : i_req0_sel;

    case (state_q)
      IDLE: begin
        if (|i_req_valid) begin
          req_ready[gnt_id] = 1'b1;
          rr_last_d = gnt_id;
          alu_sel_d = gnt_sel;
          alu_d0_d  = gnt_id ? i_req1_d0 : i_req0_d0;
          alu_d1_d  = gnt_id ? i_req1_d1 : i_req0_d1;
          alu_d2_d  = gnt_id ? i_req1_d2 : i_req0_d2;
          alu_d3_d  = gnt_id ? i_req1_d3 : i_req0_d3;
          cnt_d     = SLOW_MASK[gnt_sel] ? N_SLOW : N_FAST;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // rr_last_q still names the requester of the op in flight.
          rsp_r0_d    = i_alu_o0;
          rsp_r1_d    = i_alu_o1;
          rsp_id_d    = rr_last_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight op.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      cnt_q       <= '0;
      alu_d0_q    <= '0;
      alu_d1_q    <= '0;
      alu_d2_q    <= '0;
      alu_d3_q    <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_r0_q    <= '0;
      rsp_r1_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      cnt_q       <= cnt_d;
      alu_d0_q    <= alu_d0_d;
      alu_d1_q    <= alu_d1_d;
      alu_d2_q    <= alu_d2_d;
      alu_d3_q    <= alu_d3_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_r0_q    <= rsp_r0_d;
      rsp_r1_q    <= rsp_r1_d;
    end
  end

`ifdef ALU_OP_SCHEDULER_STATS_EN
  logic [15:0] done_cnt0_q, done_cnt0_d, done_cnt1_q, done_cnt1_d;
  logic        rsp_fire;

  // Saturating per-requester completion counters, stepped on the response handshake.
  always_comb begin
    rsp_fire    = (state_q == RESP) && i_rsp_ready;
    done_cnt0_d = done_cnt0_q;
    done_cnt1_d = done_cnt1_q;
    if (rsp_fire && !rsp_id_q && (done_cnt0_q != 16'hFFFF)) done_cnt0_d = done_cnt0_q + 16'd1;
    if (rsp_fire &&  rsp_id_q && (done_cnt1_q != 16'hFFFF)) done_cnt1_d = done_cnt1_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      done_cnt0_q <= '0;
      done_cnt1_q <= '0;
    end else begin
      done_cnt0_q <= done_cnt0_d;
      done_cnt1_q <= done_cnt1_d;
    end
  end

  assign o_done_cnt0 = done_cnt0_q;
  assign o_done_cnt1 = done_cnt1_q;
`endif

  assign o_req_ready = req_ready;
  assign o_alu_d0    = alu_d0_q;
  assign o_alu_d1    = alu_d1_q;
  assign o_alu_d2    = alu_d2_q;
  assign o_alu_d3    = alu_d3_q;
  assign o_alu_sel   = alu_sel_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_r0    = rsp_r0_q;
  assign o_rsp_r1    = rsp_r1_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed self-checking bench for alu_op_scheduler. A small combinational
// datapath model stands in for the shared ALU: o0 = d0+d1 for opcode 0,
// otherwise d0*d1 (truncated); o1 = d2^d3.
module tb_alu_op_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [1:0]  i_req_valid = 2'b00;
  logic [1:0]  o_req_ready;
  logic [15:0] i_req0_d0 = '0, i_req0_d1 = '0, i_req0_d2 = '0, i_req0_d3 = '0;
  logic [3:0]  i_req0_sel = '0;
  logic [15:0] i_req1_d0 = '0, i_req1_d1 = '0, i_req1_d2 = '0, i_req1_d3 = '0;
  logic [3:0]  i_req1_sel = '0;
  logic [15:0] o_alu_d0, o_alu_d1, o_alu_d2, o_alu_d3;
  logic [3:0]  o_alu_sel;
  logic [15:0] i_alu_o0, i_alu_o1;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic        o_rsp_id;
  logic [15:0] o_rsp_r0, o_rsp_r1;
  logic        o_busy;
`ifdef ALU_OP_SCHEDULER_STATS_EN
  logic [15:0] o_done_cnt0, o_done_cnt1;
`endif

  int n_pass   = 0;
  int n_checks = 0;

  alu_op_scheduler dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req0_d0(i_req0_d0), .i_req0_d1(i_req0_d1), .i_req0_d2(i_req0_d2), .i_req0_d3(i_req0_d3),
    .i_req0_sel(i_req0_sel),
    .i_req1_d0(i_req1_d0), .i_req1_d1(i_req1_d1), .i_req1_d2(i_req1_d2), .i_req1_d3(i_req1_d3),
    .i_req1_sel(i_req1_sel),
    .o_alu_d0(o_alu_d0), .o_alu_d1(o_alu_d1), .o_alu_d2(o_alu_d2), .o_alu_d3(o_alu_d3),
    .o_alu_sel(o_alu_sel),
    .i_alu_o0(i_alu_o0), .i_alu_o1(i_alu_o1),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id),
    .o_rsp_r0(o_rsp_r0), .o_rsp_r1(o_rsp_r1),
    .o_busy(o_busy)
`ifdef ALU_OP_SCHEDULER_STATS_EN
    ,
    .o_done_cnt0(o_done_cnt0), .o_done_cnt1(o_done_cnt1)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Datapath model.
  always_comb begin
    i_alu_o0 = (o_alu_sel == 4'h0) ? (o_alu_d0 + o_alu_d1) : 16'(o_alu_d0 * o_alu_d1);
    i_alu_o1 = o_alu_d2 ^ o_alu_d3;
  end

  // Grant must be one-hot or zero.
  assert property (@(posedge i_clk) disable iff (i_rst) o_req_ready != 2'b11)
    else $error("FAIL ready_onehot both ready bits high");

  // Requester protocol: operands stable while valid and not yet accepted.
  assert property (@(posedge i_clk) disable iff (i_rst)
    (i_req_valid[0] && !o_req_ready[0]) |=>
      $stable({i_req0_sel, i_req0_d0, i_req0_d1, i_req0_d2, i_req0_d3}))
    else $error("FAIL req0_stable operands changed while waiting");
  assert property (@(posedge i_clk) disable iff (i_rst)
    (i_req_valid[1] && !o_req_ready[1]) |=>
      $stable({i_req1_sel, i_req1_d0, i_req1_d1, i_req1_d2, i_req1_d3}))
    else $error("FAIL req1_stable operands changed while waiting");

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Runs one op from IDLE with requests already driven: checks grant, latency,
  // results, optional backpressure of `hold` cycles, then the handshake.
  task automatic run_op(input string name, input bit id, input int n,
                        input logic [15:0] r0, input logic [15:0] r1,
                        input int hold, input bit drop);
    int       lat;
    bit       ok;
    logic [3:0] sel0;
    check({name, "_ready"}, {30'd0, o_req_ready}, id ? 32'd2 : 32'd1);
    tick();
    if (drop) i_req_valid[id] = 1'b0;
    check({name, "_busy"}, {31'd0, o_busy}, 32'd1);
    sel0 = o_alu_sel;
    lat  = 0;
    ok   = 1'b1;
    while (!o_rsp_valid && lat < 20) begin
      tick();
      lat++;
      if (o_alu_sel !== sel0) ok = 1'b0;
    end
    check({name, "_latency"}, lat, n);
    check({name, "_sel_hold"}, {31'd0, ok}, 32'd1);
    check({name, "_id"}, {31'd0, o_rsp_id}, {31'd0, id});
    check({name, "_r0"}, {16'd0, o_rsp_r0}, {16'd0, r0});
    check({name, "_r1"}, {16'd0, o_rsp_r1}, {16'd0, r1});
    if (hold > 0) begin
      ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (!o_rsp_valid || o_rsp_id !== id || o_rsp_r0 !== r0 || o_rsp_r1 !== r1 ||
            o_req_ready !== 2'b00 || !o_busy) ok = 1'b0;
      end
      check({name, "_backpressure_hold"}, {31'd0, ok}, 32'd1);
    end
    check({name, "_no_accept_in_resp"}, {30'd0, o_req_ready}, 32'd0);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    check({name, "_rsp_cleared"}, {31'd0, o_rsp_valid}, 32'd0);
    check({name, "_idle"}, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    #1;
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("rst_alu_sel", {28'd0, o_alu_sel}, 32'd0);
    check("rst_alu_d0", {16'd0, o_alu_d0}, 32'd0);
    check("rst_req_ready", {30'd0, o_req_ready}, 32'd0);
    tick();
    tick();
    i_rst = 1'b0;
    tick();

    // Single fast op from requester 0: 5 + 3 = 8.
    i_req0_sel = 4'h0; i_req0_d0 = 16'd5; i_req0_d1 = 16'd3; i_req0_d2 = 16'd0; i_req0_d3 = 16'd0;
    i_req_valid = 2'b01;
    #1;
    run_op("fast0", 1'b0, 1, 16'd8, 16'd0, 0, 1'b1);
    check("alu_kept_d0", {16'd0, o_alu_d0}, 32'd5);

    // Slow op from requester 1: 7 * 6 = 42, 0xF0 ^ 0x0F = 0xFF.
    i_req1_sel = 4'hA; i_req1_d0 = 16'd7; i_req1_d1 = 16'd6; i_req1_d2 = 16'h00F0; i_req1_d3 = 16'h000F;
    i_req_valid = 2'b10;
    #1;
    run_op("slow1", 1'b1, 3, 16'd42, 16'h00FF, 0, 1'b1);

    // Response ready with nothing pending and no request is ignored.
    i_rsp_ready = 1'b1;
    tick();
    tick();
    i_rsp_ready = 1'b0;
    check("idle_rsp_ready_busy", {31'd0, o_busy}, 32'd0);
    check("idle_rsp_ready_valid", {31'd0, o_rsp_valid}, 32'd0);

    // Slow op from requester 0, reset asserted mid-settle between edges.
    i_req0_sel = 4'h3; i_req0_d0 = 16'd9; i_req0_d1 = 16'd9; i_req0_d2 = 16'd1; i_req0_d3 = 16'd2;
    i_req_valid = 2'b01;
    #1;
    check("mid_ready", {30'd0, o_req_ready}, 32'd1);
    tick();
    i_req_valid = 2'b00;
    tick();
    check("mid_busy_before", {31'd0, o_busy}, 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("mid_rst_alu_d0", {16'd0, o_alu_d0}, 32'd0);
    check("mid_rst_alu_sel", {28'd0, o_alu_sel}, 32'd0);
    tick();
    i_rst = 1'b0;
    tick();

    // Round-robin with both requesters continuously valid; requester 0 first.
    i_req0_sel = 4'h0; i_req0_d0 = 16'd1; i_req0_d1 = 16'd2; i_req0_d2 = 16'd0; i_req0_d3 = 16'd0;
    i_req1_sel = 4'h2; i_req1_d0 = 16'd4; i_req1_d1 = 16'd5; i_req1_d2 = 16'd1; i_req1_d3 = 16'd3;
    i_req_valid = 2'b11;
    #1;
    run_op("rr_a0", 1'b0, 1, 16'd3,  16'd0, 0,  1'b0);
    run_op("rr_b1", 1'b1, 3, 16'd20, 16'd2, 10, 1'b0);
    run_op("rr_c0", 1'b0, 1, 16'd3,  16'd0, 0,  1'b0);
    run_op("rr_d1", 1'b1, 3, 16'd20, 16'd2, 0,  1'b0);
    run_op("rr_e0", 1'b0, 1, 16'd3,  16'd0, 0,  1'b0);
    i_req_valid = 2'b00;
    tick();
    check("end_idle", {31'd0, o_busy}, 32'd0);

`ifdef ALU_OP_SCHEDULER_STATS_EN
    // Counters were cleared by the mid-op reset: 3 ops for req0, 2 for req1 since.
    check("stats_cnt0", {16'd0, o_done_cnt0}, 32'd3);
    check("stats_cnt1", {16'd0, o_done_cnt1}, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
